uart_rx_param: RTL



---
 rtl/uart_rx_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, half-bit start qualify, mid-bit sampling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock_50M,
    input  logic                 n_rst,
    input  logic                 rx,
    output logic                 ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 rx_meta_q;
    logic                 rxs_q;
    logic                 line;
    logic                 sample_bit;
    logic                 sample_evt;
    logic                 par_exp;

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // FSM runs one cycle behind rxs so the vote window target-1..target+1 is complete at target.
    logic rx_h1_q;
    logic rx_h2_q;

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rxs_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    assign line       = rx_h1_q;
    assign sample_bit = (rx_h2_q & rx_h1_q) | (rx_h2_q & rxs_q) | (rx_h1_q & rxs_q);
`else
    assign line       = rxs_q;
    assign sample_bit = rxs_q;
`endif

    assign sample_evt = (cnt_q == CNT_LAST);
    assign par_exp    = (PARITY_MODE == 2) ? ~(^shift_q) : ^shift_q;

    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!line) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (sample_bit) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            cnt_q     <= '0;
                            bit_cnt_q <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (sample_evt) begin
                        cnt_q   <= '0;
                        shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (sample_evt) begin
                        cnt_q     <= '0;
                        par_err_q <= (sample_bit != par_exp);
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (sample_evt) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == STOP_LAST) begin
                            // Leave at mid-stop-bit so an immediately following start edge is seen.
                            state_q      <= S_IDLE;
                            bit_cnt_q    <= '0;
                            rx_valid_q   <= 1'b1;
                            rx_data_q    <= shift_q;
                            parity_err_q <= (PARITY_MODE != 0) ? par_err_q : 1'b0;
                            frame_err_q  <= frm_err_q | ~sample_bit;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            frm_err_q <= frm_err_q | ~sample_bit;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
